// File: rtl/acc_cpu_core_if.sv
// Memory request/acknowledge bundle for acc_cpu_core.
// The core drives the request side; a memory or bus adapter answers.
interface acc_cpu_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU with req/ack memory port and a
// shift-add multiplier; no pipelining, one memory access at a time.
module acc_cpu_core #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    acc_cpu_core_if.master    mem,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              zflag,
    output logic              halted
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_MUL   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_MUL,
        S_WRITE,
        S_HALT
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] prod_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [3:0]        op_d;
    logic [ADDR_W-1:0] opa_d;
    logic              rd_op_d;
    logic              st_op_d;
    logic              halt_op_d;
    logic              take_d;
    logic              zero_d;
    logic              mul_last_d;
    logic              req_d;
    logic              we_d;
    logic [DATA_W-1:0] alu_d;
    logic [DATA_W-1:0] mul_sum_d;
    logic              ir_unused;

    assign op_d      = ir_q[DATA_W-1 -: 4];
    assign opa_d     = ir_q[ADDR_W-1:0];
    assign ir_unused = ^ir_q[DATA_W-5:0];

    assign zero_d    = (acc_q == '0);
    assign rd_op_d   = (op_d == OP_LOAD) || (op_d == OP_ADD) ||
                       (op_d == OP_SUB)  || (op_d == OP_AND) ||
                       (op_d == OP_MUL);
    assign st_op_d   = (op_d == OP_STORE);
    assign halt_op_d = (op_d == OP_HALT);
    assign take_d    = (op_d == OP_JMP) ||
                       ((op_d == OP_JZ)  &&  zero_d) ||
                       ((op_d == OP_JNZ) && !zero_d);

    // Multiplier step: add the shifted multiplicand when the
    // current low multiplier bit is set.
    assign mul_sum_d  = prod_q + (mdr_q[0] ? mcand_q : '0);
    assign mul_last_d = (cnt_q == CNT_W'(DATA_W - 1));

    // Single-cycle ALU result for the EXEC state.
    always_comb begin
        alu_d = acc_q;
        unique case (op_d)
            OP_LOAD: alu_d = mdr_q;
            OP_ADD:  alu_d = acc_q + mdr_q;
            OP_SUB:  alu_d = acc_q - mdr_q;
            OP_AND:  alu_d = acc_q & mdr_q;
            default: alu_d = acc_q;
        endcase
    end

    // Sequencer together with all architectural and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            acc_q   <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (mem.mem_ack) begin
                        ir_q    <= mem.mem_rdata;
                        pc_q    <= pc_q + ADDR_W'(1);
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    unique case (1'b1)
                        rd_op_d:   state_q <= S_READ;
                        st_op_d:   state_q <= S_WRITE;
                        halt_op_d: state_q <= S_HALT;
                        default: begin
                            if (take_d) pc_q <= opa_d;
                            state_q <= S_FETCH;
                        end
                    endcase
                end
                S_READ: begin
                    if (mem.mem_ack) begin
                        mdr_q   <= mem.mem_rdata;
                        mcand_q <= acc_q;
                        prod_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= (op_d == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    acc_q   <= alu_d;
                    state_q <= S_FETCH;
                end
                S_MUL: begin
                    prod_q  <= mul_sum_d;
                    mcand_q <= mcand_q << 1;
                    mdr_q   <= mdr_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (mul_last_d) begin
                        acc_q   <= mul_sum_d;
                        cnt_q   <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_WRITE: begin
                    if (mem.mem_ack) state_q <= S_FETCH;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Requests are a pure function of state; reset forces them idle.
    assign req_d = rst && ((state_q == S_FETCH) ||
                           (state_q == S_READ)  ||
                           (state_q == S_WRITE));
    assign we_d  = req_d && (state_q == S_WRITE);

    assign mem.mem_req   = req_d;
    assign mem.mem_we    = we_d;
    assign mem.mem_addr  = !req_d ? '0 :
                           (state_q == S_FETCH) ? pc_q : opa_d;
    assign mem.mem_wdata = we_d ? acc_q : '0;

    assign pc     = pc_q;
    assign acc    = acc_q;
    assign zflag  = zero_d;
    assign halted = (state_q == S_HALT);
endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: an ISA-level model predicts stores
// and halt state; a monitor compares them as the core produces them.
module tb_acc_cpu_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] acc;
        logic [31:0] pc;
    } hl_t;

    logic        rst16, rst24, sel;
    logic [7:0]  pc16;
    logic [15:0] acc16;
    logic        z16, h16;
    logic [11:0] pc24;
    logic [23:0] acc24;
    logic        z24, h24;

    acc_cpu_core_if #(.DATA_W(16), .ADDR_W(8))  bus16 ();
    acc_cpu_core_if #(.DATA_W(24), .ADDR_W(12)) bus24 ();

    acc_cpu_core #(.DATA_W(16), .ADDR_W(8), .RESET_PC(8'h00)) u16 (
        .clk(clk), .rst(rst16), .mem(bus16.master),
        .pc(pc16), .acc(acc16), .zflag(z16), .halted(h16)
    );

    acc_cpu_core #(.DATA_W(24), .ADDR_W(12), .RESET_PC(12'hFFF)) u24 (
        .clk(clk), .rst(rst24), .mem(bus24.master),
        .pc(pc24), .acc(acc24), .zflag(z24), .halted(h24)
    );

    logic        a_rst, a_req, a_we, a_ack, a_halt, a_z;
    logic [31:0] a_addr, a_wdata, a_rdata, a_acc, a_pc;
    logic [11:0] a_idx;

    always_comb begin
        if (sel) begin
            a_rst   = rst24;
            a_req   = bus24.mem_req;
            a_we    = bus24.mem_we;
            a_addr  = 32'(bus24.mem_addr);
            a_wdata = 32'(bus24.mem_wdata);
            a_halt  = h24;
            a_z     = z24;
            a_acc   = 32'(acc24);
            a_pc    = 32'(pc24);
        end else begin
            a_rst   = rst16;
            a_req   = bus16.mem_req;
            a_we    = bus16.mem_we;
            a_addr  = 32'(bus16.mem_addr);
            a_wdata = 32'(bus16.mem_wdata);
            a_halt  = h16;
            a_z     = z16;
            a_acc   = 32'(acc16);
            a_pc    = 32'(pc16);
        end
    end

    logic [31:0] dmem [4096];
    logic [31:0] wdat [4096];
    int          wgen [4096];
    int          gen   = 1;
    int          waits = 0;
    int          wcnt  = 0;

    assign a_idx = a_addr[11:0];
    assign a_ack = a_req && (wcnt >= waits);
    always_comb a_rdata = (wgen[a_idx] == gen) ? wdat[a_idx] : dmem[a_idx];

    assign bus16.mem_ack   = !sel && a_ack;
    assign bus16.mem_rdata = a_rdata[15:0];
    assign bus24.mem_ack   = sel && a_ack;
    assign bus24.mem_rdata = a_rdata[23:0];

    // Memory responder: ack after 'waits' wait cycles, record stores.
    always_ff @(posedge clk) begin
        if (a_req && a_ack) begin
            wcnt <= 0;
            if (a_we) begin
                wdat[a_idx] <= a_wdata;
                wgen[a_idx] <= gen;
            end
        end else if (a_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  halts_seen = 0;
    wr_t wq [$];
    hl_t hq [$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%b required=%b", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [11:0] a);
        return (wgen[a] == gen) ? wdat[a] : dmem[a];
    endfunction

    task automatic wr_dmem(input int unsigned a, input int unsigned v);
        logic [31:0] av;
        av = a;
        dmem[av[11:0]] = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) dmem[i] = '0;
    endtask

    // ISA-level reference: runs the program in memory and predicts
    // every store plus the cycle, acc and pc at which HALT is reached.
    task automatic model_run(input int dw, input int aw,
                             input int unsigned rpc, input int w);
        int unsigned dm, am, pcv, accv, mc, ins, op, a, opd;
        logic [63:0] prod;
        int unsigned mm [4096];
        bit fin;
        wr_t e;
        hl_t h;
        dm = (32'd1 << dw) - 1;
        am = (32'd1 << aw) - 1;
        for (int i = 0; i < 4096; i++) mm[i] = dmem[i] & dm;
        pcv = rpc; accv = 0; mc = 0; fin = 0;
        for (int s = 0; s < 5000 && !fin; s++) begin
            ins = mm[pcv];
            pcv = (pcv + 1) & am;
            mc += 2 + w;
            op  = ins >> (dw - 4);
            a   = ins & am;
            opd = mm[a];
            case (op)
                1: begin accv = opd; mc += 2 + w; end
                2: begin
                    mm[a] = accv;
                    e.addr = a; e.data = accv;
                    wq.push_back(e);
                    mc += 1 + w;
                end
                3: begin accv = (accv + opd) & dm; mc += 2 + w; end
                4: begin accv = (accv - opd) & dm; mc += 2 + w; end
                5: begin accv = accv & opd; mc += 2 + w; end
                6: begin
                    prod = 64'(accv) * 64'(opd);
                    accv = 32'(prod) & dm;
                    mc += 1 + w + dw;
                end
                7: pcv = a;
                8: if (accv == 0) pcv = a;
                9: if (accv != 0) pcv = a;
                15: begin
                    h.cyc = mc; h.acc = accv; h.pc = pcv;
                    hq.push_back(h);
                    fin = 1;
                end
                default: ;
            endcase
        end
    endtask

    // Forward-branching random program ending in HALT.
    task automatic gen_random(input int dw, input int aw,
                              input int unsigned rpc);
        int unsigned dm, am, base, n, op, a, ins, mid;
        int ops [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 14};
        clear_mem();
        dm   = (32'd1 << dw) - 1;
        am   = (32'd1 << aw) - 1;
        base = (aw == 8) ? 32'h80 : 32'h800;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0:       wr_dmem(base + i, 0);
                1:       wr_dmem(base + i, dm);
                default: wr_dmem(base + i, $urandom & dm);
            endcase
        end
        n = $urandom_range(6, 12);
        for (int i = 0; i < int'(n); i++) begin
            op = (i == int'(n) - 1) ? 15 : ops[$urandom_range(0, 13)];
            if (op == 7 || op == 8 || op == 9)
                a = (rpc + $urandom_range(i + 1, n - 1)) & am;
            else
                a = base + $urandom_range(0, 7);
            mid = ($urandom & ((32'd1 << (dw - 4)) - 1)) & ~am;
            ins = (op << (dw - 4)) | mid | a;
            wr_dmem((rpc + i) & am, ins);
        end
    endtask

    task automatic run_prog(input string tag, input int w);
        int  h0;
        bit  done;
        gen++;
        waits = w;
        if (sel) model_run(24, 12, 32'hFFF, w);
        else     model_run(16, 8, 32'h0, w);
        h0 = halts_seen;
        @(negedge clk);
        if (sel) rst24 = 1'b1;
        else     rst16 = 1'b1;
        done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (halts_seen != h0) done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no halt within 4000 cycles", tag);
        end
        chk({tag, "_stores_left"}, 32'(wq.size()), 32'h0);
        @(negedge clk);
        rst16 = 1'b0;
        rst24 = 1'b0;
        wq.delete();
        hq.delete();
        @(negedge clk);
    endtask

    // Cycle count since reset release, sampled by the monitor.
    initial forever begin
        @(posedge clk);
        cyc = a_rst ? cyc + 1 : 0;
    end

    // Monitor: request stability, store scoreboard and halt scoreboard.
    initial begin
        bit          pend, hseen;
        logic        p_we;
        logic [31:0] p_addr, p_wdata;
        wr_t         e;
        hl_t         hv;
        pend = 0; hseen = 0;
        p_we = 0; p_addr = 0; p_wdata = 0;
        forever begin
            @(negedge clk);
            if (!a_rst) begin
                pend  = 0;
                hseen = 0;
            end else begin
                if (pend) begin
                    checks++;
                    if (!a_req || a_we !== p_we || a_addr !== p_addr ||
                        a_wdata !== p_wdata) begin
                        failures++;
                        $display("FAIL req_hold: req=%b we=%b addr=%h wdata=%h required 1 %b %h %h",
                                 a_req, a_we, a_addr, a_wdata, p_we, p_addr, p_wdata);
                    end
                end
                pend    = a_req && !a_ack;
                p_we    = a_we;
                p_addr  = a_addr;
                p_wdata = a_wdata;
                if (a_req && a_ack && a_we) begin
                    if (wq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL store_unexpected: addr=%h data=%h required no store",
                                 a_addr, a_wdata);
                    end else begin
                        e = wq.pop_front();
                        chk("store_addr", a_addr, e.addr);
                        chk("store_data", a_wdata, e.data);
                    end
                end
                if (a_halt && !hseen) begin
                    hseen = 1;
                    if (hq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL halt_unexpected: halted=1 required 0");
                    end else begin
                        hv = hq.pop_front();
                        chk("halt_cycle", cyc, hv.cyc);
                        chk("halt_acc", a_acc, hv.acc);
                        chk("halt_pc", a_pc, hv.pc);
                        chk1("halt_zflag", a_z, hv.acc == 0);
                    end
                    halts_seen++;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag,
                                       input logic [31:0] rpc);
        chk1({tag, "_req"}, a_req, 1'b0);
        chk1({tag, "_we"}, a_we, 1'b0);
        chk({tag, "_addr"}, a_addr, 32'h0);
        chk({tag, "_wdata"}, a_wdata, 32'h0);
        chk1({tag, "_halted"}, a_halt, 1'b0);
        chk1({tag, "_zflag"}, a_z, 1'b1);
        chk({tag, "_acc"}, a_acc, 32'h0);
        chk({tag, "_pc"}, a_pc, rpc);
    endtask

    task automatic load_mul(input int unsigned x, input int unsigned y);
        clear_mem();
        wr_dmem(0, 32'h1020);
        wr_dmem(1, 32'h6021);
        wr_dmem(2, 32'hF000);
        wr_dmem(32'h20, x);
        wr_dmem(32'h21, y);
    endtask

    initial begin
        rst16 = 1'b0;
        rst24 = 1'b0;
        sel   = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst16", 32'h0);

        for (int w = 0; w <= 3; w += 3) begin
            clear_mem();
            wr_dmem(0, 32'h1020);
            wr_dmem(1, 32'h3021);
            wr_dmem(2, 32'h2022);
            wr_dmem(3, 32'hF000);
            wr_dmem(32'h20, 32'h0007);
            wr_dmem(32'h21, 32'hFFFB);
            run_prog("p1", w);
            chk("p1_m22", rd_mem(12'h022), 32'h0002);
        end

        load_mul(32'h1234, 32'h0010);
        run_prog("mul_wrap", 0);
        load_mul(32'hFFFF, 32'hFFFF);
        run_prog("mul_ones", 0);
        load_mul(32'hBEEF, 32'h0301);
        run_prog("mul_wait", 2);

        clear_mem();
        wr_dmem(0, 32'h1020);
        wr_dmem(1, 32'h4020);
        wr_dmem(2, 32'h8040);
        wr_dmem(3, 32'hF000);
        wr_dmem(32'h40, 32'hF000);
        wr_dmem(32'h20, 32'h5A5A);
        run_prog("jz", 0);

        clear_mem();
        wr_dmem(0, 32'h9005);
        wr_dmem(1, 32'h1020);
        wr_dmem(2, 32'h70FF);
        wr_dmem(5, 32'hF000);
        wr_dmem(32'hFF, 32'h0000);
        wr_dmem(32'h20, 32'h0001);
        run_prog("jnz_wrap", 1);

        clear_mem();
        load_mul(32'h1234, 32'h0010);
        gen++;
        waits = 0;
        @(negedge clk);
        rst16 = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk1("mid_mul_req", a_req, 1'b0);
        chk("mid_mul_acc", a_acc, 32'h1234);
        rst16 = 1'b0;
        #1;
        check_reset_outputs("mul_rst", 32'h0);
        @(negedge clk);
        rst16 = 1'b1;
        #1;
        chk1("release_req", a_req, 1'b1);
        chk("release_addr", a_addr, 32'h0);
        chk1("release_we", a_we, 1'b0);
        @(negedge clk);
        rst16 = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            gen_random(16, 8, 32'h0);
            run_prog("rnd16", $urandom_range(0, 3));
        end

        sel = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("rst24", 32'hFFF);

        clear_mem();
        wr_dmem(32'hFFF, 32'hBAB123);
        wr_dmem(0, 32'h100800);
        wr_dmem(1, 32'h500801);
        wr_dmem(2, 32'h200802);
        wr_dmem(3, 32'hF00000);
        wr_dmem(32'h800, 32'hF0F0F0);
        wr_dmem(32'h801, 32'h3C3CFF);
        run_prog("p24", 0);
        chk("p24_m802", rd_mem(12'h802), 32'h3030F0);

        for (int r = 0; r < 6; r++) begin
            gen_random(24, 12, 32'hFFF);
            run_prog("rnd24", $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
